irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Interrupt entry/exit controller for the pipelined RISC CPU. It latches external interrupt requests and waits until the hazard unit reports no fetch/decode hazard instruction in flight.
- It then sequences the entry: flush, push PC, push flags, fetch the vector, load the PC.
- On return-from-interrupt it sequences the reverse: pop flags, then pop PC.
- Sits beside the hazard unit and drives its interrupt-call input and the stack/PC-select controls.

Parameters:
- N_IRQ, 4, number of interrupt request lines; fixed priority, index 0 highest.
- ADDR_W, 16, PC/vector width.
- VEC_BASE, 0, vector table base address; line k uses VEC_BASE+k.
- MAX_DEPTH, 4, maximum nesting depth (used only with the optional feature).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_irq  in  N_IRQ  request lines; rising edge = request.
- i_stall_interrupt  in  1  hazard unit: hazard instruction in fetch/decode; entry must wait.
- i_rti  in  1  one-cycle pulse: RTI reached execute.
- i_mem_busy  in  1  stack memory port busy; hold the current push/pop.
- i_vec_valid  in  1  vector read data valid.
- i_vec_data  in  ADDR_W  vector read data.
- o_interrupt_call  out  1  one-cycle pulse to the hazard unit at entry.
- o_flush  out  1  flush F/D and D/EM.
- o_push_pc  out  1  push PC request.
- o_push_flags  out  1  push flags request.
- o_pop_flags  out  1  pop flags request.
- o_pop_pc  out  1  pop PC request.
- o_vec_req  out  1  vector read request.
- o_vec_addr  out  ADDR_W  vector address.
- o_pc_load  out  1  one-cycle pulse: load o_pc_value into the PC.
- o_pc_value  out  ADDR_W  new PC.
- o_ack  out  N_IRQ  one-hot, one-cycle acknowledge.
- o_active  out  1  inside an ISR (depth > 0).
- o_depth  out  $clog2(MAX_DEPTH+1)  current nesting depth.

Behaviour:
- Reset, asynchronous and immediate even mid-sequence:
  - state = IDLE; pending, sel and depth = 0; all outputs = 0.
  - The i_irq previous-value register resets to 0, so a line held high at reset release is taken as a new edge.
- Pending register, one bit per line:
  - Set on a registered rising edge of i_irq[k].
  - Cleared when o_ack[k] fires.
  - An edge in the same cycle as the ack sets the bit (set wins).
- Selection: lowest-index pending bit, captured into sel on the WAIT->FLUSH transition and held until ACTIVE.
- IDLE:
  - Any pending bit and !i_rti -> WAIT.
  - i_rti with depth 0 is ignored.
- WAIT: !i_stall_interrupt -> FLUSH; otherwise stay.
- FLUSH: o_flush = 1 and o_interrupt_call = 1 for exactly one cycle -> PUSH_PC.
- PUSH_PC: o_push_pc = 1; advance to PUSH_FLAGS in the first cycle with !i_mem_busy.
- PUSH_FLAGS: o_push_flags = 1; same busy rule -> VEC.
- VEC:
  - o_vec_req = 1, o_vec_addr = VEC_BASE + sel (ADDR_W bits, wraps modulo 2^ADDR_W).
  - On i_vec_valid, in the same cycle: o_pc_load = 1, o_pc_value = i_vec_data, o_ack[sel] = 1, depth += 1 -> ACTIVE.
- ACTIVE: i_rti -> POP_FLAGS; new pending requests remain latched and are not taken.
- POP_FLAGS: o_pop_flags = 1; advance on !i_mem_busy -> POP_PC.
- POP_PC:
  - o_pop_pc = 1; on !i_mem_busy, depth -= 1.
  - Then go to IDLE if depth becomes 0, else ACTIVE.
  - From IDLE, a pending request re-enters WAIT on the next cycle.
- Minimum latency, request edge to o_pc_load, with no stall, no busy and vector valid in the first VEC cycle: 5 cycles after the edge-register cycle.
- i_rti outside ACTIVE is ignored.
- o_active = (depth != 0).

Optional Feature:
- Macro IRQ_NESTING_EN.
- Defined:
  - In ACTIVE, a pending line with index strictly lower than the line being serviced, and depth < MAX_DEPTH -> WAIT, then the full entry sequence; depth increments.
  - The serviced-index stack is MAX_DEPTH entries.
  - At depth == MAX_DEPTH, requests stay pending.
- Undefined: no nesting; depth is 0 or 1; MAX_DEPTH is unused.

Decomposition:
- Shared package: state enum (IDLE, WAIT, FLUSH, PUSH_PC, PUSH_FLAGS, VEC, ACTIVE, POP_FLAGS, POP_PC) and state width constant.
- One sub-module, irq_priority_enc: pending vector -> valid + index, combinational, with a fixed-priority parameter.

Test Plan:
- Single request: i_irq[2] rises, no stall/busy, vec valid immediately, i_vec_data = 16'h0100 -> o_flush pulse, then push_pc, push_flags, o_vec_addr = VEC_BASE+2, o_pc_load with 16'h0100, o_ack = 4'b0100, o_depth = 1.
- Stall hold: i_stall_interrupt high 3 cycles during WAIT -> o_flush delayed exactly 3 cycles; no outputs asserted meanwhile.
- Busy stretch: i_mem_busy high 2 cycles in PUSH_PC and POP_FLAGS -> o_push_pc held 3 cycles; o_pop_flags held 3 cycles; order preserved.
- Priority: i_irq[3] and i_irq[1] rise together -> line 1 served first (o_ack = 4'b0010); after RTI line 3 is served (o_ack = 4'b1000).
- Reset mid-sequence: assert i_rst_n = 0 during PUSH_FLAGS -> all outputs 0 immediately; pending cleared; IDLE after release.
- With IRQ_NESTING_EN: in ISR for line 2, i_irq[0] rises -> nested entry, o_depth = 2; two RTIs -> o_depth = 1, then 0.

Source files
------------

// File: rtl/irq_sequencer_pkg.sv
// Shared definitions for the interrupt entry/exit sequencer.
// State encoding is fixed-width so it can be probed from legacy tooling.
package irq_sequencer_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT       = 4'd1,
        ST_FLUSH      = 4'd2,
        ST_PUSH_PC    = 4'd3,
        ST_PUSH_FLAGS = 4'd4,
        ST_VEC        = 4'd5,
        ST_ACTIVE     = 4'd6,
        ST_POP_FLAGS  = 4'd7,
        ST_POP_PC     = 4'd8
    } state_t;

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: pending vector -> valid + winning index.
// LOW_FIRST=1 gives index 0 the highest priority.
module irq_priority_enc #(
    parameter int N         = 4,
    parameter bit LOW_FIRST = 1'b1,
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     pend,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |pend;
        idx   = '0;
        if (LOW_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer beside the hazard unit.
// Define IRQ_NESTING_EN to allow higher-priority lines to preempt an ISR.
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int N_IRQ     = 4,
    parameter int ADDR_W    = 16,
    parameter int VEC_BASE  = 0,
    parameter int MAX_DEPTH = 4,
    localparam int IDX_W    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1,
    localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_IRQ-1:0]   i_irq,
    input  logic               i_stall_interrupt,
    input  logic               i_rti,
    input  logic               i_mem_busy,
    input  logic               i_vec_valid,
    input  logic [ADDR_W-1:0]  i_vec_data,
    output logic               o_interrupt_call,
    output logic               o_flush,
    output logic               o_push_pc,
    output logic               o_push_flags,
    output logic               o_pop_flags,
    output logic               o_pop_pc,
    output logic               o_vec_req,
    output logic [ADDR_W-1:0]  o_vec_addr,
    output logic               o_pc_load,
    output logic [ADDR_W-1:0]  o_pc_value,
    output logic [N_IRQ-1:0]   o_ack,
    output logic               o_active,
    output logic [DEPTH_W-1:0] o_depth
);

    state_t             state, state_nx;
    logic [N_IRQ-1:0]   irq_prev, pending, edge_det, ack;
    logic [IDX_W-1:0]   sel, enc_idx;
    logic               enc_valid;
    logic [DEPTH_W-1:0] depth;
    logic               vec_done, pop_done, take_nest;

    irq_priority_enc #(
        .N        (N_IRQ),
        .LOW_FIRST(1'b1)
    ) u_enc (
        .pend (pending),
        .valid(enc_valid),
        .idx  (enc_idx)
    );

    assign edge_det = i_irq & ~irq_prev;
    assign vec_done = (state == ST_VEC) && i_vec_valid;
    assign pop_done = (state == ST_POP_PC) && !i_mem_busy;
    assign ack      = vec_done ? (N_IRQ'(1) << sel) : '0;

`ifdef IRQ_NESTING_EN
    localparam int SP_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    // Index of each line currently being serviced, innermost on top.
    logic [IDX_W-1:0] stack_q [MAX_DEPTH];
    logic [IDX_W-1:0] cur_idx;

    assign cur_idx   = stack_q[SP_W'(depth - DEPTH_W'(1))];
    assign take_nest = enc_valid && (enc_idx < cur_idx)
                     && (depth < DEPTH_W'(MAX_DEPTH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MAX_DEPTH; i++) stack_q[i] <= '0;
        end else if (vec_done) begin
            stack_q[SP_W'(depth)] <= sel;
        end
    end
`else
    assign take_nest = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:       if (|pending && !i_rti) state_nx = ST_WAIT;
            ST_WAIT:       if (!i_stall_interrupt) state_nx = ST_FLUSH;
            ST_FLUSH:      state_nx = ST_PUSH_PC;
            ST_PUSH_PC:    if (!i_mem_busy) state_nx = ST_PUSH_FLAGS;
            ST_PUSH_FLAGS: if (!i_mem_busy) state_nx = ST_VEC;
            ST_VEC:        if (i_vec_valid) state_nx = ST_ACTIVE;
            ST_ACTIVE: begin
                if (i_rti)          state_nx = ST_POP_FLAGS;
                else if (take_nest) state_nx = ST_WAIT;
            end
            ST_POP_FLAGS:  if (!i_mem_busy) state_nx = ST_POP_PC;
            ST_POP_PC: begin
                if (!i_mem_busy)
                    state_nx = (depth == DEPTH_W'(1)) ? ST_IDLE : ST_ACTIVE;
            end
            default:       state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            irq_prev <= '0;
            pending  <= '0;
            sel      <= '0;
            depth    <= '0;
        end else begin
            state    <= state_nx;
            irq_prev <= i_irq;
            // A fresh edge beats the ack clearing the same bit.
            pending  <= (pending & ~ack) | edge_det;
            if (state == ST_WAIT && !i_stall_interrupt) sel <= enc_idx;
            if (vec_done)      depth <= depth + DEPTH_W'(1);
            else if (pop_done) depth <= depth - DEPTH_W'(1);
        end
    end

    assign o_interrupt_call = (state == ST_FLUSH);
    assign o_flush          = (state == ST_FLUSH);
    assign o_push_pc        = (state == ST_PUSH_PC);
    assign o_push_flags     = (state == ST_PUSH_FLAGS);
    assign o_pop_flags      = (state == ST_POP_FLAGS);
    assign o_pop_pc         = (state == ST_POP_PC);
    assign o_vec_req        = (state == ST_VEC);
    assign o_vec_addr       = o_vec_req
                            ? ADDR_W'(VEC_BASE) + ADDR_W'(sel) : '0;
    assign o_pc_load        = vec_done;
    assign o_pc_value       = vec_done ? i_vec_data : '0;
    assign o_ack            = ack;
    assign o_active         = (depth != '0);
    assign o_depth          = depth;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer with hand-computed expectations.
// Nesting steps are built only when IRQ_NESTING_EN is defined.
module tb_irq_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [3:0]  i_irq;
    logic        i_stall_interrupt;
    logic        i_rti;
    logic        i_mem_busy;
    logic        i_vec_valid;
    logic [15:0] i_vec_data;
    logic        o_interrupt_call, o_flush, o_push_pc, o_push_flags;
    logic        o_pop_flags, o_pop_pc, o_vec_req, o_pc_load, o_active;
    logic [15:0] o_vec_addr, o_pc_value;
    logic [3:0]  o_ack;
    logic [2:0]  o_depth;

    int checks   = 0;
    int failures = 0;

    irq_sequencer dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_irq            (i_irq),
        .i_stall_interrupt(i_stall_interrupt),
        .i_rti            (i_rti),
        .i_mem_busy       (i_mem_busy),
        .i_vec_valid      (i_vec_valid),
        .i_vec_data       (i_vec_data),
        .o_interrupt_call (o_interrupt_call),
        .o_flush          (o_flush),
        .o_push_pc        (o_push_pc),
        .o_push_flags     (o_push_flags),
        .o_pop_flags      (o_pop_flags),
        .o_pop_pc         (o_pop_pc),
        .o_vec_req        (o_vec_req),
        .o_vec_addr       (o_vec_addr),
        .o_pc_load        (o_pc_load),
        .o_pc_value       (o_pc_value),
        .o_ack            (o_ack),
        .o_active         (o_active),
        .o_depth          (o_depth)
    );

    always #5 i_clk = ~i_clk;

    logic [11:0] strobes;
    assign strobes = {o_interrupt_call, o_flush, o_push_pc, o_push_flags,
                      o_pop_flags, o_pop_pc, o_vec_req, o_pc_load, o_ack};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_irq = '0;
        i_stall_interrupt = 1'b0;
        i_rti = 1'b0;
        i_mem_busy = 1'b0;
        i_vec_valid = 1'b1;
        i_vec_data = 16'h0100;
        #1;
        chk("rst_strobes", strobes, 0);
        chk("rst_addr", {o_vec_addr, o_pc_value}, 0);
        chk("rst_depth", {o_active, o_depth}, 0);
        cyc(2);
        i_rst_n = 1'b1;

        // single request on line 2
        i_irq = 4'b0100;
        cyc(1); chk("t1_idle", strobes, 0);
        cyc(1); chk("t1_wait", strobes, 0);
        cyc(1); chk("t1_flush", {o_flush, o_interrupt_call}, 2'b11);
        cyc(1); chk("t1_push_pc", {o_push_pc, o_flush}, 2'b10);
        cyc(1); chk("t1_push_flags", {o_push_flags, o_push_pc}, 2'b10);
        cyc(1);
        chk("t1_vec_addr", {o_vec_req, o_vec_addr}, {1'b1, 16'd2});
        chk("t1_pc_load", {o_pc_load, o_pc_value}, {1'b1, 16'h0100});
        chk("t1_ack", o_ack, 4'b0100);
        chk("t1_depth_pre", o_depth, 0);
        cyc(1);
        chk("t1_active", {o_active, o_depth}, {1'b1, 3'd1});
        chk("t1_active_strobes", strobes, 0);
        i_irq = '0;
        i_rti = 1'b1;
        cyc(1); i_rti = 1'b0;
        chk("t1_pop_flags", {o_pop_flags, o_pop_pc}, 2'b10);
        cyc(1); chk("t1_pop_pc", {o_pop_flags, o_pop_pc}, 2'b01);
        chk("t1_pop_depth", o_depth, 1);
        cyc(1); chk("t1_idle_depth", {o_active, o_depth}, 0);

        // stray RTI in IDLE
        i_rti = 1'b1;
        cyc(1); i_rti = 1'b0;
        chk("rti_idle_strobes", strobes, 0);
        cyc(1); chk("rti_idle_depth", o_depth, 0);

        // stall hold and busy stretch on line 1
        i_stall_interrupt = 1'b1;
        i_vec_data = 16'h0200;
        i_irq = 4'b0010;
        cyc(1);
        cyc(1); chk("t2_wait0", strobes, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1); chk("t2_wait_stall", strobes, 0);
        end
        i_stall_interrupt = 1'b0;
        i_mem_busy = 1'b1;
        cyc(1); chk("t2_flush", o_flush, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t2_push_pc_hold", {o_push_pc, o_push_flags}, 2'b10);
        end
        i_mem_busy = 1'b0;
        cyc(1); chk("t2_push_flags", {o_push_pc, o_push_flags}, 2'b01);
        cyc(1);
        chk("t2_vec", {o_vec_addr, o_pc_value}, {16'd1, 16'h0200});
        chk("t2_ack", o_ack, 4'b0010);
        cyc(1);
        i_irq = '0;
        i_mem_busy = 1'b1;
        i_rti = 1'b1;
        cyc(1); i_rti = 1'b0;
        chk("t2_pop_flags0", {o_pop_flags, o_pop_pc}, 2'b10);
        cyc(1); chk("t2_pop_flags1", {o_pop_flags, o_pop_pc}, 2'b10);
        cyc(1); chk("t2_pop_flags2", {o_pop_flags, o_pop_pc}, 2'b10);
        i_mem_busy = 1'b0;
        cyc(1); chk("t2_pop_pc", {o_pop_flags, o_pop_pc}, 2'b01);
        cyc(1); chk("t2_idle", {o_active, o_depth}, 0);

        // simultaneous lines 3 and 1
        i_vec_data = 16'h0300;
        i_irq = 4'b1010;
        cyc(6);
        chk("t3_ack_first", o_ack, 4'b0010);
        chk("t3_addr_first", o_vec_addr, 16'd1);
        cyc(1);
        cyc(2); chk("t3_hold_active", {strobes, o_depth}, {12'd0, 3'd1});
        i_vec_data = 16'h0400;
        i_rti = 1'b1;
        cyc(1); i_rti = 1'b0;
        cyc(1);
        cyc(1); chk("t3_idle_between", o_depth, 0);
        cyc(1);
        cyc(1); chk("t3_flush2", o_flush, 1);
        cyc(3);
        chk("t3_ack_second", o_ack, 4'b1000);
        chk("t3_vec2", {o_vec_addr, o_pc_value}, {16'd3, 16'h0400});
        cyc(1);
        i_irq = '0;
        i_rti = 1'b1;
        cyc(1); i_rti = 1'b0;
        cyc(2); chk("t3_done", {o_active, o_depth}, 0);

        // reset in PUSH_FLAGS
        i_irq = 4'b0001;
        cyc(5); chk("t4_push_flags", o_push_flags, 1);
        i_rst_n = 1'b0;
        #1;
        chk("t4_rst_strobes", strobes, 0);
        chk("t4_rst_depth", {o_active, o_depth}, 0);
        i_irq = '0;
        cyc(1);
        i_rst_n = 1'b1;
        cyc(4); chk("t4_pending_cleared", strobes, 0);

        // line held high through reset release counts as an edge
        i_rst_n = 1'b0;
        i_irq = 4'b0001;
        i_vec_data = 16'h0500;
        cyc(1);
        i_rst_n = 1'b1;
        cyc(3); chk("t4_held_flush", o_flush, 1);
        cyc(3);
        chk("t4_held_ack", {o_ack, o_pc_value}, {4'b0001, 16'h0500});
        cyc(1);
        i_irq = '0;
        i_rti = 1'b1;
        cyc(1); i_rti = 1'b0;
        cyc(2); chk("t4_held_done", o_depth, 0);

`ifdef IRQ_NESTING_EN
        i_vec_data = 16'h0600;
        i_irq = 4'b0100;
        cyc(6); chk("t5_ack_outer", o_ack, 4'b0100);
        cyc(1); chk("t5_depth1", o_depth, 1);
        i_irq = 4'b0101;
        i_vec_data = 16'h0700;
        cyc(1);
        cyc(1); chk("t5_wait", {o_flush, o_depth}, {1'b0, 3'd1});
        cyc(1); chk("t5_flush", o_flush, 1);
        cyc(3);
        chk("t5_ack_inner", {o_ack, o_pc_value}, {4'b0001, 16'h0700});
        cyc(1); chk("t5_depth2", o_depth, 2);
        i_irq = '0;
        i_rti = 1'b1;
        cyc(1); i_rti = 1'b0;
        cyc(2); chk("t5_back_depth1", {o_active, o_depth}, {1'b1, 3'd1});
        i_rti = 1'b1;
        cyc(1); i_rti = 1'b0;
        cyc(2); chk("t5_back_depth0", {o_active, o_depth}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
